// File: rtl/ecc_pkg.sv
// Shared ECC read-path definitions: word geometry, scrub FSM states, error classes.
package ecc_pkg;

  localparam int DATA_WIDTH   = 26;
  localparam int PARITY_WIDTH = 6;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_SBIT = 2'd1,
    ERR_DBIT = 2'd2
  } err_class_e;

endpackage

// File: rtl/ecc_skid_buf.sv
// Two-entry in-order valid/ready skid buffer; 1-cycle latency when empty.
// s_ready is decoded from the occupancy register only, so it never depends on m_ready.
module ecc_skid_buf #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_dat,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_dat
);

  logic [1:0]   count;
  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic         push;
  logic         pop;

  assign s_ready = (count != 2'd2);
  assign m_valid = (count != 2'd0);
  assign m_dat   = head;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      unique case (count)
        2'd0: begin
          if (push) begin
            head  <= s_dat;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= s_dat;
          end else if (push) begin
            tail  <= s_dat;
            count <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          // Full: no push possible, a pop promotes the skid entry.
          if (pop) begin
            head  <= tail;
            count <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ecc_26_rd_chk.sv
// Post-SECDED read check: skid-buffered data path, saturating error stats with first-error
// capture, sticky dbit interrupt, and a single-entry scrub write-back request for sbit words.
module ecc_26_rd_chk
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 26,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic                  s_sbit_err,
  input  logic                  s_dbit_err,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_dbit_err,
  output logic                  wb_req,
  input  logic                  wb_ack,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  stat_clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  wb_drop_cnt,
  output logic                  first_err_vld,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  first_err_dbit,
  output logic                  err_irq
);

  logic        accept;
  err_class_e  err_cls;
  logic        sbit_ev;
  logic        dbit_ev;
  logic        drop_ev;
  wb_state_e   wb_state;

  logic [CNT_WIDTH-1:0] sbit_base;
  logic [CNT_WIDTH-1:0] dbit_base;
  logic [CNT_WIDTH-1:0] drop_base;
  logic                 first_base;
  logic                 irq_base;

  ecc_skid_buf #(.W(DATA_WIDTH + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_dat   ({s_dbit_err, s_data}),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_dat   ({m_dbit_err, m_data})
  );

  assign accept = s_valid && s_ready;

  // dbit dominates: a word flagged both ways is uncorrectable.
  always_comb begin
    err_cls = ERR_NONE;
    if (accept && s_dbit_err)      err_cls = ERR_DBIT;
    else if (accept && s_sbit_err) err_cls = ERR_SBIT;
  end

  assign sbit_ev = (err_cls == ERR_SBIT);
  assign dbit_ev = (err_cls == ERR_DBIT);
  assign drop_ev = sbit_ev && (wb_state == WB_REQ) && !wb_ack;

  // Clear first, then fold in this cycle's events.
  always_comb begin
    sbit_base  = stat_clr ? '0 : sbit_cnt;
    dbit_base  = stat_clr ? '0 : dbit_cnt;
    drop_base  = stat_clr ? '0 : wb_drop_cnt;
    first_base = stat_clr ? 1'b0 : first_err_vld;
    irq_base   = stat_clr ? 1'b0 : err_irq;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt       <= '0;
      dbit_cnt       <= '0;
      wb_drop_cnt    <= '0;
      first_err_vld  <= 1'b0;
      first_err_addr <= '0;
      first_err_dbit <= 1'b0;
      err_irq        <= 1'b0;
    end else begin
      sbit_cnt    <= (sbit_ev && sbit_base != '1) ? sbit_base + 1'b1 : sbit_base;
      dbit_cnt    <= (dbit_ev && dbit_base != '1) ? dbit_base + 1'b1 : dbit_base;
      wb_drop_cnt <= (drop_ev && drop_base != '1) ? drop_base + 1'b1 : drop_base;
      err_irq     <= irq_base || dbit_ev;
      if (stat_clr) begin
        first_err_addr <= '0;
        first_err_dbit <= 1'b0;
      end
      first_err_vld <= first_base || sbit_ev || dbit_ev;
      if (!first_base && (sbit_ev || dbit_ev)) begin
        first_err_addr <= s_addr;
        first_err_dbit <= dbit_ev;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_state <= WB_IDLE;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      unique case (wb_state)
        WB_IDLE: begin
          if (sbit_ev) begin
            wb_state <= WB_REQ;
            wb_addr  <= s_addr;
            wb_data  <= s_data;
          end
        end
        default: begin
          // Payload only changes on the ack edge; an unacked collision is counted as a drop.
          if (wb_ack) begin
            if (sbit_ev) begin
              wb_addr <= s_addr;
              wb_data <= s_data;
            end else begin
              wb_state <= WB_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign wb_req = (wb_state == WB_REQ);

endmodule

// File: tb/tb_ecc_26_rd_chk.sv
// Directed bench for ecc_26_rd_chk: data path ordering/backpressure, error stats, scrub FSM,
// clear priority, counter saturation and mid-stream reset.
module tb_ecc_26_rd_chk;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [25:0] s_data;
  logic [7:0]  s_addr;
  logic        s_sbit_err;
  logic        s_dbit_err;
  logic        m_valid;
  logic        m_ready;
  logic [25:0] m_data;
  logic        m_dbit_err;
  logic        wb_req;
  logic        wb_ack;
  logic [7:0]  wb_addr;
  logic [25:0] wb_data;
  logic        stat_clr;
  logic [15:0] sbit_cnt;
  logic [15:0] dbit_cnt;
  logic [15:0] wb_drop_cnt;
  logic        first_err_vld;
  logic [7:0]  first_err_addr;
  logic        first_err_dbit;
  logic        err_irq;

  int errors = 0;
  int checks = 0;
  logic saw_wb_req;

  always #5 clk = ~clk;

  ecc_26_rd_chk dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_addr         (s_addr),
    .s_sbit_err     (s_sbit_err),
    .s_dbit_err     (s_dbit_err),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_dbit_err     (m_dbit_err),
    .wb_req         (wb_req),
    .wb_ack         (wb_ack),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .stat_clr       (stat_clr),
    .sbit_cnt       (sbit_cnt),
    .dbit_cnt       (dbit_cnt),
    .wb_drop_cnt    (wb_drop_cnt),
    .first_err_vld  (first_err_vld),
    .first_err_addr (first_err_addr),
    .first_err_dbit (first_err_dbit),
    .err_irq        (err_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [25:0] d, input logic [7:0] a,
                       input logic sb, input logic db);
    s_valid    = v;
    s_data     = d;
    s_addr     = a;
    s_sbit_err = sb;
    s_dbit_err = db;
  endtask

  initial begin
    rst = 1'b1; m_ready = 1'b1; wb_ack = 1'b0; stat_clr = 1'b0;
    drive(1'b0, 26'h0, 8'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_s_ready", 32'(s_ready), 32'h1);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_wb_req", 32'(wb_req), 32'h0);
    chk("rst_counts", 32'({sbit_cnt, dbit_cnt} | 32'(wb_drop_cnt)), 32'h0);
    chk("rst_flags", 32'({first_err_vld, first_err_dbit, err_irq}), 32'h0);
    rst = 1'b0;

    // 8 clean words back to back, each visible one cycle after its accept.
    saw_wb_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 26'h0ABC000 + 26'(i * 17), 8'(i), 1'b0, 1'b0);
      step();
      chk("b2b_m_valid", 32'(m_valid), 32'h1);
      chk("b2b_m_data", 32'(m_data), 32'h0ABC000 + 32'(i * 17));
      saw_wb_req |= wb_req;
    end
    drive(1'b0, 26'h0, 8'h0, 1'b0, 1'b0);
    step();
    saw_wb_req |= wb_req;
    chk("b2b_drain", 32'(m_valid), 32'h0);
    chk("b2b_counts", 32'({sbit_cnt, dbit_cnt} | 32'(wb_drop_cnt)), 32'h0);
    chk("b2b_no_wb_req", 32'(saw_wb_req), 32'h0);

    // Backpressure: two accepts fill the buffer, the third word waits.
    m_ready = 1'b0;
    drive(1'b1, 26'h1111111, 8'h01, 1'b0, 1'b0);
    step();
    chk("bp_first_s_ready", 32'(s_ready), 32'h1);
    chk("bp_first_data", 32'(m_data), 32'h1111111);
    drive(1'b1, 26'h2222222, 8'h02, 1'b0, 1'b0);
    step();
    chk("bp_full_s_ready", 32'(s_ready), 32'h0);
    drive(1'b1, 26'h3333333, 8'h03, 1'b0, 1'b0);
    step();
    chk("bp_hold_s_ready", 32'(s_ready), 32'h0);
    chk("bp_hold_data", 32'(m_data), 32'h1111111);
    m_ready = 1'b1;
    step();
    chk("bp_out2", 32'(m_data), 32'h2222222);
    chk("bp_reopen", 32'(s_ready), 32'h1);
    step();
    chk("bp_out3", 32'(m_data), 32'h3333333);
    drive(1'b0, 26'h0, 8'h0, 1'b0, 1'b0);
    step();
    chk("bp_empty", 32'(m_valid), 32'h0);

    // Single-bit error launches a scrub; a second one before ack is dropped.
    drive(1'b1, 26'h2AAAAAA, 8'h12, 1'b1, 1'b0);
    step();
    chk("sb_wb_req", 32'(wb_req), 32'h1);
    chk("sb_wb_addr", 32'(wb_addr), 32'h12);
    chk("sb_wb_data", 32'(wb_data), 32'h2AAAAAA);
    chk("sb_cnt", 32'(sbit_cnt), 32'h1);
    chk("sb_first", 32'({first_err_vld, first_err_dbit, first_err_addr}), 32'h212);
    chk("sb_m_dbit", 32'(m_dbit_err), 32'h0);
    drive(1'b1, 26'h1555555, 8'h13, 1'b1, 1'b0);
    step();
    chk("drop_cnt", 32'(wb_drop_cnt), 32'h1);
    chk("drop_wb_addr", 32'(wb_addr), 32'h12);
    chk("drop_wb_data", 32'(wb_data), 32'h2AAAAAA);
    chk("drop_sbit_cnt", 32'(sbit_cnt), 32'h2);
    drive(1'b0, 26'h0, 8'h0, 1'b0, 1'b0);
    wb_ack = 1'b1;
    step();
    chk("ack_idle", 32'(wb_req), 32'h0);
    step();
    chk("ack_ignored_idle", 32'(wb_req), 32'h0);
    wb_ack = 1'b0;

    // Double-bit error (sbit also set): poison travels, no scrub.
    drive(1'b1, 26'h0000040, 8'h40, 1'b1, 1'b1);
    step();
    chk("db_cnt", 32'(dbit_cnt), 32'h1);
    chk("db_irq", 32'(err_irq), 32'h1);
    chk("db_m_dbit", 32'(m_dbit_err), 32'h1);
    chk("db_no_wb", 32'(wb_req), 32'h0);
    chk("db_sbit_unchanged", 32'(sbit_cnt), 32'h2);
    chk("db_first_kept", 32'({first_err_dbit, first_err_addr}), 32'h012);

    // Clear coinciding with a dbit event: clear first, then the event.
    drive(1'b1, 26'h0000055, 8'h55, 1'b0, 1'b1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_ev_dbit_cnt", 32'(dbit_cnt), 32'h1);
    chk("clr_ev_irq", 32'(err_irq), 32'h1);
    chk("clr_ev_first", 32'({first_err_vld, first_err_dbit, first_err_addr}), 32'h355);
    chk("clr_ev_sbit_cnt", 32'(sbit_cnt), 32'h0);
    chk("clr_ev_drop", 32'(wb_drop_cnt), 32'h0);
    drive(1'b0, 26'h0, 8'h0, 1'b0, 1'b0);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_only", 32'({err_irq, first_err_vld} | 2'(dbit_cnt != 16'h0)), 32'h0);

    // Saturation: 65535 sbit events reach all-ones, one more must not wrap.
    wb_ack = 1'b1;
    drive(1'b1, 26'h0000077, 8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 65535; i++) step();
    chk("sat_reach", 32'(sbit_cnt), 32'hFFFF);
    step();
    chk("sat_hold", 32'(sbit_cnt), 32'hFFFF);
    chk("sat_no_drop_on_ack", 32'(wb_drop_cnt), 32'h0);

    // Reset mid-stream discards buffered data and the pending scrub.
    m_ready = 1'b0;
    step();
    chk("pre_rst_m_valid", 32'(m_valid), 32'h1);
    chk("pre_rst_wb_req", 32'(wb_req), 32'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_m_valid", 32'(m_valid), 32'h0);
    chk("mid_rst_s_ready", 32'(s_ready), 32'h1);
    chk("mid_rst_wb_req", 32'(wb_req), 32'h0);
    chk("mid_rst_sbit_cnt", 32'(sbit_cnt), 32'h0);
    rst = 1'b0;
    drive(1'b0, 26'h0, 8'h0, 1'b0, 1'b0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
